// File: rtl/sprite_dma_if.sv
// Bus-side signals of the sprite DMA: Z80 bus handshake, work-RAM read port
// and objram write port.
interface sprite_dma_if #(
  parameter int SRC_AW = 16
);
  logic              busrq_n;
  logic              busak_n;
  logic              src_rd;
  logic [SRC_AW-1:0] src_addr;
  logic [7:0]        src_data;
  logic              dst_wr;
  logic [9:0]        dst_addr;
  logic [7:0]        dst_data;

  modport master (
    output busrq_n, src_rd, src_addr, dst_wr, dst_addr, dst_data,
    input  busak_n, src_data
  );

  modport slave (
    input  busrq_n, src_rd, src_addr, dst_wr, dst_addr, dst_data,
    output busak_n, src_data
  );
endinterface

// File: rtl/sprite_dma.sv
// Sprite-list DMA: on a CPU trigger, takes the Z80 bus and copies LEN bytes
// from work RAM into objram, two clocks per byte, then hands the bus back.
module sprite_dma #(
  parameter int LEN    = 384,
  parameter int SRC_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SRC_AW-1:0] src_base,
  input  logic [9:0]        dst_base,
  output logic              busy,
  output logic              done,
  sprite_dma_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_WR,
    S_REL
  } state_e;

  localparam logic [10:0] LEN_C = 11'(LEN);

  state_e            state_q, state_d;
  logic [SRC_AW-1:0] src_ptr_q, src_ptr_d;
  logic [9:0]        dst_ptr_q, dst_ptr_d;
  logic [10:0]       count_q, count_d;

  logic              busrq_n_q, busrq_n_d;
  logic              src_rd_q, src_rd_d;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic              dst_wr_q, dst_wr_d;
  logic [9:0]        dst_addr_q, dst_addr_d;
  logic [7:0]        dst_data_q, dst_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              last_byte;

  assign last_byte = (count_q + 11'd1) == LEN_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      count_q    <= '0;
      busrq_n_q  <= 1'b1;
      src_rd_q   <= 1'b0;
      src_addr_q <= '0;
      dst_wr_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      count_q    <= count_d;
      busrq_n_q  <= busrq_n_d;
      src_rd_q   <= src_rd_d;
      src_addr_q <= src_addr_d;
      dst_wr_q   <= dst_wr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    count_d    = count_q;
    busrq_n_d  = busrq_n_q;
    src_rd_d   = 1'b0;
    src_addr_d = src_addr_q;
    dst_wr_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A trigger landing on the done pulse belongs to the finished transfer.
        if (start && !done_q) begin
          src_ptr_d = src_base;
          dst_ptr_d = dst_base;
          count_d   = '0;
          busy_d    = 1'b1;
          busrq_n_d = 1'b0;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (!bus.busak_n) state_d = S_RD;
      end

      S_RD: begin
        if (bus.busak_n) begin
          state_d = S_REQ;
        end else begin
          src_rd_d   = 1'b1;
          src_addr_d = src_ptr_q;
          state_d    = S_WR;
        end
      end

      S_WR: begin
        // Losing the bus here drops the byte; it is re-read after re-acknowledge.
        if (bus.busak_n) begin
          state_d = S_REQ;
        end else begin
          dst_wr_d   = 1'b1;
          dst_addr_d = dst_ptr_q;
          dst_data_d = bus.src_data;
          src_ptr_d  = src_ptr_q + SRC_AW'(1);
          dst_ptr_d  = dst_ptr_q + 10'd1;
          count_d    = count_q + 11'd1;
          if (last_byte) begin
            busrq_n_d = 1'b1;
            state_d   = S_REL;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_REL: begin
        busrq_n_d = 1'b1;
        if (bus.busak_n) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busrq_n  = busrq_n_q;
  assign bus.src_rd   = src_rd_q;
  assign bus.src_addr = src_addr_q;
  assign bus.dst_wr   = dst_wr_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_data = dst_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sprite_dma.sv
// Bench for sprite_dma: Z80 arbiter and work-RAM models, expected objram
// writes queued per transfer and compared by an independent monitor.
module tb_sprite_dma;

  localparam int LEN    = 384;
  localparam int SRC_AW = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] src_base;
  logic [9:0]  dst_base;
  logic        busy;
  logic        done;

  sprite_dma_if #(.SRC_AW(SRC_AW)) bus_if ();

  sprite_dma #(.LEN(LEN), .SRC_AW(SRC_AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .busy     (busy),
    .done     (done),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic [9:0]  dst;
    logic [7:0]  data;
  } wr_t;

  wr_t  exp_q[$];
  int   total     = 0;
  int   bad       = 0;
  int   done_seen = 0;
  int   exp_done  = 0;

  logic [7:0] key  = 8'h5A;
  bit         mix  = 1'b0;
  logic [7:0] junk = 8'h00;

  logic [7:0] rq_hist    = 8'hFF;
  int         ack_dly    = 2;
  bit         stim_hold  = 1'b0;
  bit         rnd_en     = 1'b0;
  int         rnd_cnt    = 0;
  logic       ak_at_edge = 1'b1;

  // Work-RAM contents as a pure function of address.
  function automatic logic [7:0] pat(input logic [15:0] a, input logic [7:0] k, input bit m);
    return a[7:0] ^ k ^ (m ? a[15:8] : 8'h00);
  endfunction

  assign bus_if.src_data = bus_if.src_rd ? pat(bus_if.src_addr, key, mix) : junk;

  // Arbiter: acknowledge follows request after ack_dly clocks; may be withheld.
  always @(negedge clk) begin
    rq_hist = {rq_hist[6:0], bus_if.busrq_n};
    if (rnd_en && rnd_cnt == 0 && !bus_if.busrq_n && $urandom_range(63) == 0)
      rnd_cnt = $urandom_range(4, 1);
    else if (rnd_cnt > 0)
      rnd_cnt = rnd_cnt - 1;
    bus_if.busak_n = (stim_hold || rnd_cnt != 0) ? 1'b1 : rq_hist[ack_dly];
    junk = 8'($urandom);
  end

  always @(posedge clk) ak_at_edge <= bus_if.busak_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic prev_done;
    wr_t  e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.src_rd || bus_if.dst_wr)
        chk("strobe_excl", 32'(bus_if.src_rd & bus_if.dst_wr), 0);
      if (bus_if.src_rd) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: src_addr=0x%0h with no transfer pending", bus_if.src_addr);
        end else begin
          chk("rd_addr", 32'(bus_if.src_addr), 32'(exp_q[0].src));
        end
      end
      if (bus_if.dst_wr) begin
        chk("wr_while_revoked", 32'(ak_at_edge), 0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: dst_addr=0x%0h with no write pending", bus_if.dst_addr);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus_if.dst_addr), 32'(e.dst));
          chk("wr_data", 32'(bus_if.dst_data), 32'(e.data));
          $display("write dst=0x%03h data=0x%02h", bus_if.dst_addr, bus_if.dst_data);
        end
      end
      if (done) begin
        done_seen++;
        chk("done_width", 32'(prev_done), 0);
      end
      prev_done = done;
    end
  endtask

  task automatic issue(input logic [15:0] s, input logic [9:0] d);
    wr_t e;
    @(negedge clk);
    src_base = s;
    dst_base = d;
    start    = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      e.src  = s + 16'(i);
      e.dst  = d + 10'(i);
      e.data = pat(e.src, key, mix);
      exp_q.push_back(e);
    end
    exp_done++;
    $display("start src=0x%04h dst=0x%03h key=0x%02h", s, d, key);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_writes(input string name, input int n);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      if (LEN - exp_q.size() >= n) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL %s_timeout: fewer than %0d writes within budget", name, n);
    end
  endtask

  task automatic wait_done(input string name, input bit retrig, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (retrig) start = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: no done within %0d clocks", name, budget);
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"},     32'(busy), 0);
    chk({name, "_busrq_n"},  32'(bus_if.busrq_n), 1);
    chk({name, "_left"},     32'(exp_q.size()), 0);
    chk({name, "_done_cnt"}, 32'(done_seen), 32'(exp_done));
    $display("done %s", name);
  endtask

  initial begin
    int bad0;
    rst_n    = 1'b0;
    start    = 1'b0;
    src_base = '0;
    dst_base = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busrq_n",  32'(bus_if.busrq_n), 1);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_done",     32'(done), 0);
    chk("rst_src_rd",   32'(bus_if.src_rd), 0);
    chk("rst_dst_wr",   32'(bus_if.dst_wr), 0);
    chk("rst_src_addr", 32'(bus_if.src_addr), 0);
    chk("rst_dst_addr", 32'(bus_if.dst_addr), 0);
    chk("rst_dst_data", 32'(bus_if.dst_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy with the reference pattern.
    key = 8'h5A; mix = 1'b0; ack_dly = 2;
    issue(16'h6900, 10'h000);
    wait_done("basic", 1'b0, 4000);

    // Bank 1 with objram and source address wrap.
    key = 8'($urandom); mix = 1'b1;
    issue(16'hFFF0, 10'h300);
    wait_done("wrap", 1'b0, 4000);

    // Triggers while busy and on the done clock are ignored.
    key = 8'($urandom);
    issue(16'($urandom), 10'($urandom));
    wait_writes("retrig", 10);
    @(negedge clk);
    src_base = 16'h1234; dst_base = 10'h155; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("retrig", 1'b1, 4000);
    repeat (20) @(negedge clk);
    chk("retrig_idle_busy", 32'(busy), 0);
    chk("retrig_idle_rq",   32'(bus_if.busrq_n), 1);
    chk("retrig_done_cnt",  32'(done_seen), 32'(exp_done));

    // Bus revoked for 5 clocks during the write phase of byte 100.
    key = 8'($urandom);
    issue(16'h2000, 10'h080);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 4000; c++) begin
        @(posedge clk);
        #2;
        if (LEN - exp_q.size() == 100 && bus_if.src_rd) begin
          hit = 1'b1;
          break;
        end
      end
      if (!hit) begin
        total++; bad++;
        $display("FAIL revoke_trigger: read of byte 100 never observed");
      end
    end
    stim_hold = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #2;
      chk("revoke_busrq_n", 32'(bus_if.busrq_n), 0);
    end
    stim_hold = 1'b0;
    wait_done("revoke", 1'b0, 4000);

    // Asynchronous reset mid-transfer, then a fresh transfer.
    key = 8'($urandom);
    issue(16'h4100, 10'h200);
    wait_writes("reset", 50);
    rst_n = 1'b0;
    #1;
    chk("async_busrq_n", 32'(bus_if.busrq_n), 1);
    chk("async_busy",    32'(busy), 0);
    chk("async_src_rd",  32'(bus_if.src_rd), 0);
    chk("async_dst_wr",  32'(bus_if.dst_wr), 0);
    exp_q.delete();
    exp_done--;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    key = 8'($urandom);
    issue(16'h5A00, 10'h010);
    wait_done("post_reset", 1'b0, 4000);

    // Acknowledge withheld for 1000 clocks.
    stim_hold = 1'b1;
    key = 8'($urandom);
    issue(16'($urandom), 10'($urandom));
    bad0 = bad;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      chk("ackwait_state", 32'({busy, bus_if.busrq_n, bus_if.src_rd, bus_if.dst_wr}), 32'h8);
      if (bad != bad0) break;
    end
    stim_hold = 1'b0;
    wait_done("ackwait", 1'b0, 4000);

    // Random bases, patterns, ack latency and bus revocations.
    for (int r = 0; r < 3; r++) begin
      ack_dly = $urandom_range(5, 0);
      key     = 8'($urandom);
      rnd_en  = 1'b1;
      issue(16'($urandom), 10'($urandom));
      wait_done("random", 1'b0, 8000);
      rnd_en  = 1'b0;
      repeat (10) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
